// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - per-lane next-PC, NZP and optional return stack (PC_RET_STACK_EN)
module pc_unit #(
   parameter int THREADS     = 4,
   parameter int DATA_BITS   = 8,
   parameter int PC_BITS     = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [THREADS-1:0]            thread_mask,
   input  logic [2:0]                    core_state,
   input  logic [2:0]                    decoded_nzp,
   input  logic [DATA_BITS-1:0]          decoded_immediate,
   input  logic                          decoded_nzp_write_enable,
   input  logic                          decoded_pc_mux,
   input  logic                          decoded_call,
   input  logic                          decoded_ret,
   input  logic [THREADS*DATA_BITS-1:0]  alu_out,
   input  logic [PC_BITS-1:0]            current_pc,
   output logic [THREADS*PC_BITS-1:0]    next_pc,
   output logic                          converged,
   output logic [PC_BITS-1:0]            converged_pc,
   output logic [THREADS-1:0]            stack_overflow,
   output logic [THREADS-1:0]            stack_underflow
);

   localparam logic [2:0] ST_EXECUTE = 3'b101;
   localparam logic [2:0] ST_UPDATE  = 3'b110;

   logic [PC_BITS-1:0] r_next_pc [THREADS];
   logic [2:0]         r_nzp     [THREADS];

   wire [PC_BITS-1:0] w_pc_plus1 = current_pc + PC_BITS'(1);
   wire [PC_BITS-1:0] w_imm      = decoded_immediate[PC_BITS-1:0];

`ifdef PC_RET_STACK_EN
   localparam int SP_BITS  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [SP_BITS-1:0]  r_sp       [THREADS];
   logic [PC_BITS-1:0]  r_stack    [THREADS][STACK_DEPTH];
   logic [THREADS-1:0]  r_ovf;
   logic [THREADS-1:0]  r_unf;
   logic [IDX_BITS-1:0] w_top_idx  [THREADS];
   logic [IDX_BITS-1:0] w_push_idx [THREADS];

   // Stack addresses: the pointer counts entries, so top is pointer-1 and the push slot is pointer
   always_comb begin
      for (int i = 0; i < THREADS; i++) begin
         w_top_idx[i]  = IDX_BITS'(r_sp[i] - SP_BITS'(1));
         w_push_idx[i] = IDX_BITS'(r_sp[i]);
      end
   end

   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;

   wire w_unused = &{1'b0, alu_out, decoded_immediate};
`else
   assign stack_overflow  = '0;
   assign stack_underflow = '0;

   wire w_unused = &{1'b0, alu_out, decoded_immediate, decoded_call, decoded_ret, STACK_DEPTH[0]};
`endif

   // Per-lane state: next PC on EXECUTE, NZP on UPDATE, frozen when disabled or masked off
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < THREADS; i++) begin
            r_next_pc[i] <= '0;
            r_nzp[i]     <= '0;
`ifdef PC_RET_STACK_EN
            r_sp[i]      <= '0;
            for (int j = 0; j < STACK_DEPTH; j++) r_stack[i][j] <= '0;
`endif
         end
`ifdef PC_RET_STACK_EN
         r_ovf <= '0;
         r_unf <= '0;
`endif
      end else if (enable) begin
         for (int i = 0; i < THREADS; i++) begin
            if (thread_mask[i]) begin
               if (core_state == ST_EXECUTE) begin
`ifdef PC_RET_STACK_EN
                  if (decoded_ret) begin
                     if (r_sp[i] == '0) begin
                        r_unf[i]     <= 1'b1;
                        r_next_pc[i] <= w_pc_plus1;
                     end else begin
                        r_next_pc[i] <= r_stack[i][w_top_idx[i]];
                        r_sp[i]      <= r_sp[i] - SP_BITS'(1);
                     end
                  end else if (decoded_call) begin
                     if (r_sp[i] == SP_BITS'(STACK_DEPTH)) begin
                        r_ovf[i] <= 1'b1;
                     end else begin
                        r_stack[i][w_push_idx[i]] <= w_pc_plus1;
                        r_sp[i]                   <= r_sp[i] + SP_BITS'(1);
                     end
                     r_next_pc[i] <= w_imm;
                  end else
`endif
                  if (decoded_pc_mux && ((r_nzp[i] & decoded_nzp) != 3'b000))
                     r_next_pc[i] <= w_imm;
                  else
                     r_next_pc[i] <= w_pc_plus1;
               end else if (core_state == ST_UPDATE) begin
                  if (decoded_nzp_write_enable)
                     r_nzp[i] <= alu_out[i*DATA_BITS +: 3];
               end
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < THREADS; g++) begin : g_lane_out
         assign next_pc[g*PC_BITS +: PC_BITS] = r_next_pc[g];
      end
   endgenerate

   logic [PC_BITS-1:0] w_conv_pc;
   logic               w_found;
   logic               w_converged;

   // Convergence: reference is the lowest active lane; all other active lanes must match it
   always_comb begin
      w_conv_pc   = '0;
      w_found     = 1'b0;
      w_converged = 1'b1;
      for (int i = 0; i < THREADS; i++) begin
         if (thread_mask[i] && !w_found) begin
            w_conv_pc = r_next_pc[i];
            w_found   = 1'b1;
         end
      end
      for (int i = 0; i < THREADS; i++) begin
         if (thread_mask[i] && (r_next_pc[i] != w_conv_pc))
            w_converged = 1'b0;
      end
   end

   assign converged    = w_converged;
   assign converged_pc = w_conv_pc;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [3:0]  thread_mask;
   logic [2:0]  core_state;
   logic [2:0]  decoded_nzp;
   logic [7:0]  decoded_immediate;
   logic        decoded_nzp_write_enable;
   logic        decoded_pc_mux;
   logic        decoded_call;
   logic        decoded_ret;
   logic [31:0] alu_out;
   logic [7:0]  current_pc;
   logic [31:0] next_pc;
   logic        converged;
   logic [7:0]  converged_pc;
   logic [3:0]  stack_overflow;
   logic [3:0]  stack_underflow;

   int n_vec = 0;
   int n_bad = 0;

   localparam logic [2:0] EXE = 3'b101;
   localparam logic [2:0] UPD = 3'b110;
   localparam logic [2:0] IDLE = 3'b000;

   pc_unit dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .thread_mask(thread_mask),
      .core_state(core_state), .decoded_nzp(decoded_nzp),
      .decoded_immediate(decoded_immediate),
      .decoded_nzp_write_enable(decoded_nzp_write_enable),
      .decoded_pc_mux(decoded_pc_mux), .decoded_call(decoded_call),
      .decoded_ret(decoded_ret), .alu_out(alu_out), .current_pc(current_pc),
      .next_pc(next_pc), .converged(converged), .converged_pc(converged_pc),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      core_state = IDLE; decoded_nzp = 3'b000; decoded_immediate = 8'h00;
      decoded_nzp_write_enable = 1'b0; decoded_pc_mux = 1'b0;
      decoded_call = 1'b0; decoded_ret = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exec(input logic [7:0] pc, input logic br, input logic [2:0] nzp,
                       input logic [7:0] imm, input logic call, input logic ret);
      idle_inputs();
      core_state = EXE; current_pc = pc; decoded_pc_mux = br; decoded_nzp = nzp;
      decoded_immediate = imm; decoded_call = call; decoded_ret = ret;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b1; thread_mask = 4'hF; alu_out = '0; current_pc = '0;
      idle_inputs();
      #12;
      chk("reset_next_pc", next_pc, 32'h0);
      chk("reset_converged", 32'(converged), 32'h1);
      chk("reset_conv_pc", 32'(converged_pc), 32'h0);
      chk("reset_ovf", 32'(stack_overflow), 32'h0);
      chk("reset_unf", 32'(stack_underflow), 32'h0);
      reset_n = 1'b1;
      #1;

      // Sequential execution, NZP cleared by reset so a branch-on-anything falls through
      exec(8'h10, 1'b1, 3'b111, 8'h40, 1'b0, 1'b0);
      chk("seq_0x11", next_pc, 32'h11111111);
      chk("seq_conv0", 32'(converged), 32'h1);
      exec(8'h11, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      chk("seq_0x12", next_pc, 32'h12121212);
      exec(8'h12, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      chk("seq_0x13", next_pc, 32'h13131313);
      chk("seq_conv2", 32'(converged), 32'h1);
      chk("seq_conv_pc", 32'(converged_pc), 32'h13);

      // UPDATE loads NZP per lane: lane0=100 lane1=001 lane2=100 lane3=010
      idle_inputs();
      core_state = UPD; decoded_nzp_write_enable = 1'b1; alu_out = 32'hFA_F9_FC_04;
      alu_out = 32'h02_04_01_04;
      tick();
      chk("update_holds_pc", next_pc, 32'h13131313);

      exec(8'h05, 1'b1, 3'b100, 8'h40, 1'b0, 1'b0);
      chk("brn_lanes", next_pc, 32'h06400640);
      chk("brn_converged", 32'(converged), 32'h0);
      chk("brn_conv_pc", 32'(converged_pc), 32'h40);

      // Masking and PC wrap
      thread_mask = 4'b0101;
      exec(8'hFF, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      chk("wrap_mask_lanes", next_pc, 32'h06000600);
      chk("wrap_converged", 32'(converged), 32'h1);
      chk("wrap_conv_pc", 32'(converged_pc), 32'h00);
      thread_mask = 4'b0000; #1;
      chk("nomask_converged", 32'(converged), 32'h1);
      chk("nomask_conv_pc", 32'(converged_pc), 32'h00);
      thread_mask = 4'b0010; #1;
      chk("lane1_conv_pc", 32'(converged_pc), 32'h06);
      thread_mask = 4'b0011; #1;
      chk("mixed_converged", 32'(converged), 32'h0);
      chk("mixed_conv_pc", 32'(converged_pc), 32'h00);

      // NZP persisted: BRp hits lane 1 only; immediate wider than PC is truncated (same width here)
      thread_mask = 4'hF;
      exec(8'h20, 1'b1, 3'b001, 8'h50, 1'b0, 1'b0);
      chk("brp_lane1", next_pc, 32'h21215021);

      // Non-enabled and non-EXECUTE cycles change nothing
      enable = 1'b0;
      exec(8'h70, 1'b1, 3'b111, 8'h77, 1'b0, 1'b0);
      chk("disabled_hold", next_pc, 32'h21215021);
      enable = 1'b1;
      idle_inputs(); current_pc = 8'h70; tick();
      chk("idle_state_hold", next_pc, 32'h21215021);

`ifdef PC_RET_STACK_EN
      exec(8'h08, 1'b0, 3'b000, 8'h30, 1'b1, 1'b0);
      chk("call_target", next_pc, 32'h30303030);
      exec(8'h31, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
      chk("ret_target", next_pc, 32'h09090909);
      chk("callret_ovf", 32'(stack_overflow), 32'h0);
      chk("callret_unf", 32'(stack_underflow), 32'h0);
      for (int k = 0; k < 5; k++) begin
         exec(8'(k), 1'b0, 3'b000, 8'(8'h60 + k), 1'b1, 1'b0);
         chk($sformatf("call%0d_target", k), next_pc, {4{8'(8'h60 + k)}});
      end
      chk("ovf_set", 32'(stack_overflow), 32'hF);
      for (int k = 0; k < 4; k++) begin
         exec(8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
         chk($sformatf("ret%0d_target", k), next_pc, {4{8'(4 - k)}});
      end
      chk("unf_clear_before", 32'(stack_underflow), 32'h0);
      exec(8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
      chk("ret_empty_pc", next_pc, 32'h81818181);
      chk("unf_set", 32'(stack_underflow), 32'hF);
      exec(8'h90, 1'b0, 3'b000, 8'h33, 1'b1, 1'b1);
      chk("ret_call_ret_wins", next_pc, 32'h91919191);
      exec(8'hA0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
      chk("ret_call_no_push", next_pc, 32'hA1A1A1A1);
      chk("ovf_sticky", 32'(stack_overflow), 32'hF);
      chk("unf_sticky", 32'(stack_underflow), 32'hF);
`else
      exec(8'h08, 1'b0, 3'b000, 8'h30, 1'b1, 1'b0);
      chk("call_ignored", next_pc, 32'h09090909);
      exec(8'h31, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
      chk("ret_ignored", next_pc, 32'h32323232);
      chk("flags_ovf_zero", 32'(stack_overflow), 32'h0);
      chk("flags_unf_zero", 32'(stack_underflow), 32'h0);
`endif

      // Asynchronous reset in the middle of an EXECUTE cycle
      exec(8'h44, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
      chk("pre_reset_pc", next_pc, 32'h45454545);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_pc", next_pc, 32'h0);
      chk("async_reset_ovf", 32'(stack_overflow), 32'h0);
      chk("async_reset_unf", 32'(stack_underflow), 32'h0);
      chk("async_reset_conv", 32'(converged), 32'h1);
      #3 reset_n = 1'b1;
      @(negedge clk);

      // NZP cleared by reset: branch falls through
      exec(8'h10, 1'b1, 3'b111, 8'h40, 1'b0, 1'b0);
      chk("post_reset_nzp", next_pc, 32'h11111111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #50000;
      n_bad++;
      $display("FAIL timeout observed running expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Per-thread program-counter unit for one compute core; successor to the single-thread next-PC block. It computes `next_pc` for every thread lane independently and keeps a private NZP register and an optional return-address stack per lane. It also reports whether the active lanes still agree on a single PC, which the core scheduler uses to detect divergence. It sits between the decoder/ALUs and the core's fetch control.

## Interface
- `THREADS`, 4: thread lanes per core (≥1).
- `DATA_BITS`, 8: ALU/immediate width.
- `PC_BITS`, 8: program-memory address width (≤ `DATA_BITS`).
- `STACK_DEPTH`, 4: return-stack entries per lane (≥1; used only with the configuration macro).

- `clk` in 1: clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: block enable; low freezes all state.
- `thread_mask` in THREADS: per-lane active bit.
- `core_state` in 3: core FSM state; EXECUTE = 3'b101, UPDATE = 3'b110.
- `decoded_nzp` in 3: branch condition mask.
- `decoded_immediate` in DATA_BITS: branch/call target.
- `decoded_nzp_write_enable` in 1: CMP writes NZP.
- `decoded_pc_mux` in 1: BRnzp instruction.
- `decoded_call` in 1: CALL instruction.
- `decoded_ret` in 1: RET instruction.
- `alu_out` in THREADS*DATA_BITS: lane i occupies bits [i*DATA_BITS +: DATA_BITS].
- `current_pc` in PC_BITS: core's current PC.
- `next_pc` out THREADS*PC_BITS: per-lane next PC, registered.
- `converged` out 1: all active lanes hold the same `next_pc`.
- `converged_pc` out PC_BITS: `next_pc` of the lowest-indexed active lane.
- `stack_overflow` out THREADS: sticky per-lane push-when-full flag.
- `stack_underflow` out THREADS: sticky per-lane pop-when-empty flag.

## Operation
- **Reset** (`reset_n` = 0, asynchronous): all of the following are cleared to 0 regardless of `clk` or `enable`: `next_pc`, every NZP register, every stack pointer and entry, `stack_overflow`, and `stack_underflow`.
- **Disabled** (`enable` = 0): no state changes.
- **Inactive lanes** (`thread_mask[i]` = 0): the lane holds its `next_pc`, NZP, and stack.
- **EXECUTE**, per active lane, evaluated in priority order:
  1. `decoded_ret`: pop. If the stack is empty, set `stack_underflow[i]` and take `current_pc+1`; otherwise `next_pc` ← top entry and decrement the pointer.
  2. `decoded_call`: push `current_pc+1` and set `next_pc` ← `decoded_immediate[PC_BITS-1:0]`. If the stack is full, set `stack_overflow[i]`, drop the push, and take the jump anyway.
  3. `decoded_pc_mux`: if `(nzp_i & decoded_nzp) != 0`, set `next_pc` ← `decoded_immediate[PC_BITS-1:0]`; otherwise `current_pc+1`.
  4. Otherwise: `current_pc+1`.
- If `decoded_ret` and `decoded_call` are both asserted, RET wins and no push occurs.
- **UPDATE**: if `decoded_nzp_write_enable` is set, each active lane loads `nzp_i` ← `alu_out` lane i, bits [2:0].
- **Other `core_state` values**: no state changes.
- **Arithmetic**:
  - `current_pc+1` wraps modulo 2^PC_BITS (0xFF+1 → 0x00 at the default width).
  - Immediates are truncated to PC_BITS.
- **Convergence** (combinational from `next_pc` registers and `thread_mask`):
  - `converged` = 1 when every active lane's `next_pc` equals `converged_pc`.
  - If no lane is active: `converged` = 1 and `converged_pc` = 0.
- **Sticky flags** clear only on reset.

## Timing
- `next_pc` and the stack update on the rising edge at which `core_state` = EXECUTE and `enable` = 1. The new values are visible the following cycle.
- NZP updates on the UPDATE edge, so a CMP in UPDATE is visible to a BRnzp in the next instruction's EXECUTE.
- `converged` and `converged_pc` settle combinationally in the same cycle `next_pc` changes; there is no additional latency.
- A CALL or RET takes exactly one EXECUTE edge.
- Back-to-back instructions need no stall.
- Reset asserted mid-instruction clears state immediately. Deassertion is expected to be synchronous to `clk`.

## Configuration
- `PC_RET_STACK_EN` defined:
  - Per-lane return stacks of `STACK_DEPTH` entries.
  - CALL/RET behave as described in Operation.
- `PC_RET_STACK_EN` undefined:
  - No stack storage.
  - `decoded_call` and `decoded_ret` are ignored; those instructions take the branch/PC+1 path.
  - `stack_overflow` and `stack_underflow` are tied to 0.

## Test plan
- **Reset**: reset, `THREADS`=4, all lanes active, three EXECUTE cycles with `current_pc` = 0x10, 0x11, 0x12 and no branch → every lane reads `next_pc` 0x11, 0x12, 0x13; `converged` = 1 throughout.
- **Divergent branch**: UPDATE with `alu_out` lanes = {3'b100, 3'b001, 3'b100, 3'b010}, then BRn to 0x40 at `current_pc` = 0x05 → lanes 0 and 2 read 0x40, lanes 1 and 3 read 0x06; `converged` = 0; `converged_pc` = 0x40.
- **Masking and wrap**: `thread_mask` = 4'b0101 at `current_pc` = 0xFF → lanes 0 and 2 read 0x00, lanes 1 and 3 hold their previous values; masking to 4'b0000 yields `converged` = 1 and `converged_pc` = 0.
- **Call/return**: with the macro defined, CALL 0x30 at PC 0x08, then RET at PC 0x31 → `next_pc` = 0x30, then 0x09; no flags set.
- **Stack limits**: with `STACK_DEPTH`=4, perform five CALLs → fifth sets `stack_overflow` = 4'b1111 and still jumps. Then five RETs → the last sets `stack_underflow` and returns `current_pc+1`. Both flags persist until `reset_n` pulses low.
- **Async reset and enable**: `reset_n` low mid-cycle during EXECUTE → outputs clear before the next edge. Separately, `enable` = 0 during EXECUTE leaves `next_pc` unchanged.
